// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - LFSR random word generator with valid/ready word output
// Optional feature macro: LFSR_STREAM_LOCKUP_COUNT_EN adds the lockup_count output.
module lfsr_stream #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE = 16'hACE1,
  parameter logic [WIDTH-1:0] FEEDBACK   = 16'h002D,
  parameter int               MODE       = 0,
  parameter int               OUT_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                random,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  output logic [OUT_BITS-1:0] out_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    shiftreg
`ifdef LFSR_STREAM_LOCKUP_COUNT_EN
  ,
  output logic [15:0]         lockup_count
`endif
);

  // Counter must be able to hold OUT_BITS after the final step of a word.
  localparam int CW = $clog2(OUT_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         bit_cnt;
  logic [WIDTH-1:0]      fib_next;
  logic [WIDTH-1:0]      gal_next;
  logic [WIDTH-1:0]      step_raw;
  logic [WIDTH-1:0]      step_val;
  logic                  step_zero;
  logic [WIDTH-1:0]      seed_val;
  logic                  seed_zero;
  logic [OUT_BITS-1:0]   word_next;
  logic                  do_step;
  logic                  last_bit;
  logic                  handshake;

  // Next LFSR value for both topologies, with substitution of the all-zero lock-up state.
  always_comb begin
    fib_next  = {random ^ (^(shiftreg & FEEDBACK)), shiftreg[WIDTH-1:1]};
    gal_next  = {random, shiftreg[WIDTH-1:1]} ^ (shiftreg[0] ? FEEDBACK : '0);
    step_raw  = (MODE == 1) ? gal_next : fib_next;
    step_zero = (step_raw == '0);
    step_val  = step_zero ? INIT_VALUE : step_raw;
    seed_zero = (seed == '0);
    seed_val  = seed_zero ? INIT_VALUE : seed;
  end

  // The pre-step LSB enters the word at the top and older bits move down.
  generate
    if (OUT_BITS == 1) begin : g_word_one
      assign word_next = shiftreg[0];
    end else begin : g_word_many
      assign word_next = {shiftreg[0], out_word[OUT_BITS-1:1]};
    end
  endgenerate

  assign last_bit  = (bit_cnt == LAST);
  assign handshake = out_valid && out_ready;

  // FSM next state: FILL steps every cycle, HOLD waits for the consumer; seed_load restarts filling.
  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    case (state_q)
      FILL: begin
        do_step = 1'b1;
        if (last_bit) state_d = HOLD;
      end
      HOLD: begin
        if (handshake) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    if (seed_load) state_d = FILL;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  // Datapath: seed_load beats stepping and the handshake clear; nothing moves in HOLD otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shiftreg  <= INIT_VALUE;
      out_word  <= '0;
      out_valid <= 1'b0;
      bit_cnt   <= '0;
    end else if (seed_load) begin
      shiftreg  <= seed_val;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (do_step) begin
      shiftreg <= step_val;
      out_word <= word_next;
      bit_cnt  <= bit_cnt + CW'(1);
      if (last_bit) out_valid <= 1'b1;
    end else if (handshake) begin
      bit_cnt   <= '0;
      out_valid <= 1'b0;
    end
  end

`ifdef LFSR_STREAM_LOCKUP_COUNT_EN
  logic zero_sub;
  assign zero_sub = seed_load ? seed_zero : (do_step && step_zero);

  // Saturating count of every time INIT_VALUE replaced an all-zero state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lockup_count <= '0;
    end else if (zero_sub && (lockup_count != 16'hFFFF)) begin
      lockup_count <= lockup_count + 16'd1;
    end
  end
`endif

endmodule
